// File: rtl/counter_4b_udl.sv
// 4-bit up/down/up-by-3 counter with parallel load, registered ripple-carry/borrow
// flag and a modulo-4 wrap-event counter; asynchronous active-low reset.
module counter_4b_udl (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [1:0] modo,
  input  logic [3:0] data,
  output logic [3:0] Q,
  output logic       rco,
  output logic [1:0] count
);

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W:0]     step_res;
  logic [DATA_W-1:0]   q_nxt;
  logic                rco_nxt;
  logic [1:0]          cnt_nxt;

  // Returns {wrap, next_q}; wrap is the carry out of the 5-bit sum, or the
  // borrow when stepping down from zero.
  function automatic logic [DATA_W:0] step(input logic [DATA_W-1:0] q,
                                           input logic [1:0]        m);
    logic [DATA_W:0] res;
    unique case (m)
      2'b00:   res = {1'b0, q} + 5'd1;
      2'b01:   res = {(q == '0), q - 4'd1};
      2'b10:   res = {1'b0, q} + 5'd3;
      default: res = {1'b0, q};
    endcase
    return res;
  endfunction

  always_comb begin
    state_nxt = IDLE;
    if (enb) state_nxt = (modo == 2'b11) ? LOAD : RUN;
  end

  always_comb begin
    q_nxt    = Q;
    rco_nxt  = rco;
    cnt_nxt  = count;
    step_res = step(Q, modo);
    unique case (state_nxt)
      RUN: begin
        q_nxt   = step_res[DATA_W-1:0];
        rco_nxt = step_res[DATA_W];
        cnt_nxt = count + {1'b0, step_res[DATA_W]};
      end
      // data is only ever routed to Q here, so it cannot leak in other modes
      LOAD: begin
        q_nxt   = data;
        rco_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // p0: state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      Q     <= '0;
      rco   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nxt;
      Q     <= q_nxt;
      rco   <= rco_nxt;
      count <= cnt_nxt;
    end
  end

  a_load_clears_rco: assert property (@(posedge clk) disable iff (!rst)
    (state == LOAD) |-> !rco);

endmodule
